pong_score_keeper: RTL and testbench

- Synchronous, parametrised replacement for the per-player rally-score counters in the pong top level.
- Counts paddle hits per player as multi-digit BCD and clears a player's rally on a missed ball.
- Tracks each player's best rally and detects a winning score.
- Takes hit/miss levels straight from game_module2018fall, with internal edge detection, so no external one-shots are needed. Outputs feed VGA7SegDisplay instances.

---
 rtl/pong_score_keeper_if.sv | 27 ++
 rtl/pong_score_keeper.sv | 150 +++++++++++++++
 tb/tb_pong_score_keeper.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_score_keeper_if.sv
// Player input levels and score/status outputs of the pong score keeper.
// The master side drives hit/miss/clear; the slave side is the keeper.
interface pong_score_keeper_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_DIGITS  = 2
);
    localparam int SW = NUM_PLAYERS * NUM_DIGITS * 4;

    logic [NUM_PLAYERS-1:0] hit;
    logic [NUM_PLAYERS-1:0] miss;
    logic                   clear;
    logic [SW-1:0]          score_bcd;
    logic [SW-1:0]          best_bcd;
    logic                   score_event;
    logic                   game_over;
    logic [1:0]             winner;

    modport master (
        output hit, miss, clear,
        input  score_bcd, best_bcd, score_event, game_over, winner
    );

    modport slave (
        input  hit, miss, clear,
        output score_bcd, best_bcd, score_event, game_over, winner
    );
endinterface

// File: rtl/pong_score_keeper.sv
// Per-player BCD rally counters with edge-detected hit/miss levels,
// best-rally tracking and optional win detection.
module pong_score_keeper #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_DIGITS  = 2,
    parameter int WIN_SCORE   = 0,
    parameter int WRAP_MODE   = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    pong_score_keeper_if.slave  sk
);
    localparam int DW        = NUM_DIGITS * 4;
    localparam int SW        = NUM_PLAYERS * DW;
    localparam int MAX_SCORE = 10 ** NUM_DIGITS - 1;
    localparam int CW        = $clog2(MAX_SCORE + 1);
    localparam logic [CW-1:0] MAX_SH = CW'(MAX_SCORE);
    localparam logic [CW-1:0] WIN_SH = CW'(WIN_SCORE);

    typedef enum logic {PLAY, OVER} state_t;

    logic [NUM_PLAYERS-1:0] hit_prev_q, hit_prev_d;
    logic [NUM_PLAYERS-1:0] miss_prev_q, miss_prev_d;
    logic [NUM_PLAYERS-1:0] hit_rise, miss_rise;
    logic [SW-1:0]          score_q, score_d;
    logic [SW-1:0]          best_q, best_d;
    logic [CW-1:0]          shadow_q [NUM_PLAYERS];
    logic [CW-1:0]          shadow_d [NUM_PLAYERS];
    logic [CW-1:0]          best_shadow_q [NUM_PLAYERS];
    logic [CW-1:0]          best_shadow_d [NUM_PLAYERS];
    logic                   event_q, event_d;
    state_t                 state_q, state_d;
    logic [1:0]             winner_q, winner_d;
    logic                   win_found;
    logic [1:0]             win_idx;

    function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
        logic       carry;
        logic [3:0] dig;
        bcd_inc = v;
        carry   = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            dig = v[k*4 +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    bcd_inc[k*4 +: 4] = 4'd0;
                end else begin
                    bcd_inc[k*4 +: 4] = dig + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    endfunction

    always_comb begin
        hit_rise      = sk.hit & ~hit_prev_q;
        miss_rise     = sk.miss & ~miss_prev_q;
        hit_prev_d    = sk.hit;
        miss_prev_d   = sk.miss;
        score_d       = score_q;
        best_d        = best_q;
        shadow_d      = shadow_q;
        best_shadow_d = best_shadow_q;
        state_d       = state_q;
        winner_d      = winner_q;
        event_d       = 1'b0;
        win_found     = 1'b0;
        win_idx       = '0;

        // Best follows the registered score one cycle late, in either state.
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (shadow_q[p] > best_shadow_q[p]) begin
                best_d[p*DW +: DW] = score_q[p*DW +: DW];
                best_shadow_d[p]   = shadow_q[p];
            end
        end

        if (sk.clear) begin
            score_d  = '0;
            best_d   = '0;
            state_d  = PLAY;
            winner_d = '0;
            event_d  = |score_q;
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                shadow_d[p]      = '0;
                best_shadow_d[p] = '0;
            end
        end else if (state_q == PLAY) begin
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                if (miss_rise[p]) begin
                    if (shadow_q[p] != '0) begin
                        score_d[p*DW +: DW] = '0;
                        shadow_d[p]         = '0;
                        event_d             = 1'b1;
                    end
                end else if (hit_rise[p]) begin
                    if (shadow_q[p] == MAX_SH) begin
                        if (WRAP_MODE != 0) begin
                            score_d[p*DW +: DW] = '0;
                            shadow_d[p]         = '0;
                            event_d             = 1'b1;
                        end
                    end else begin
                        score_d[p*DW +: DW] = bcd_inc(score_q[p*DW +: DW]);
                        shadow_d[p]         = shadow_q[p] + CW'(1);
                        event_d             = 1'b1;
                        if (WIN_SCORE != 0 && shadow_d[p] == WIN_SH && !win_found) begin
                            win_found = 1'b1;
                            win_idx   = 2'(p);
                        end
                    end
                end
            end
            if (win_found) begin
                state_d  = OVER;
                winner_d = win_idx;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hit_prev_q    <= '0;
            miss_prev_q   <= '0;
            score_q       <= '0;
            best_q        <= '0;
            shadow_q      <= '{default: '0};
            best_shadow_q <= '{default: '0};
            event_q       <= 1'b0;
            state_q       <= PLAY;
            winner_q      <= '0;
        end else begin
            hit_prev_q    <= hit_prev_d;
            miss_prev_q   <= miss_prev_d;
            score_q       <= score_d;
            best_q        <= best_d;
            shadow_q      <= shadow_d;
            best_shadow_q <= best_shadow_d;
            event_q       <= event_d;
            state_q       <= state_d;
            winner_q      <= winner_d;
        end
    end

    assign sk.score_bcd   = score_q;
    assign sk.best_bcd    = best_q;
    assign sk.score_event = event_q;
    assign sk.game_over   = (state_q == OVER);
    assign sk.winner      = winner_q;
endmodule

// File: tb/tb_pong_score_keeper.sv
// Drives three keeper configurations (wrap, saturate, win at 11) with shared
// stimulus and compares every cycle against a decimal-integer reference model.
module tb_pong_score_keeper;
    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [1:0] hit   = 2'b00;
    logic [1:0] miss  = 2'b00;
    logic       clear = 1'b0;

    int checks = 0;
    int errors = 0;
    int ev_cnt = 0;

    always #5 Clock = ~Clock;

    pong_score_keeper_if #(.NUM_PLAYERS(2), .NUM_DIGITS(2)) if0 ();
    pong_score_keeper_if #(.NUM_PLAYERS(2), .NUM_DIGITS(2)) if1 ();
    pong_score_keeper_if #(.NUM_PLAYERS(2), .NUM_DIGITS(2)) if2 ();

    assign if0.hit = hit;  assign if0.miss = miss;  assign if0.clear = clear;
    assign if1.hit = hit;  assign if1.miss = miss;  assign if1.clear = clear;
    assign if2.hit = hit;  assign if2.miss = miss;  assign if2.clear = clear;

    pong_score_keeper #(.NUM_PLAYERS(2), .NUM_DIGITS(2), .WIN_SCORE(0), .WRAP_MODE(1))
        u0 (.Clock(Clock), .Reset(Reset), .sk(if0));
    pong_score_keeper #(.NUM_PLAYERS(2), .NUM_DIGITS(2), .WIN_SCORE(0), .WRAP_MODE(0))
        u1 (.Clock(Clock), .Reset(Reset), .sk(if1));
    pong_score_keeper #(.NUM_PLAYERS(2), .NUM_DIGITS(2), .WIN_SCORE(11), .WRAP_MODE(1))
        u2 (.Clock(Clock), .Reset(Reset), .sk(if2));

    logic [15:0] obs_score [3];
    logic [15:0] obs_best  [3];
    logic        obs_event [3];
    logic        obs_over  [3];
    logic [1:0]  obs_win   [3];

    assign obs_score[0] = if0.score_bcd;  assign obs_best[0] = if0.best_bcd;
    assign obs_event[0] = if0.score_event; assign obs_over[0] = if0.game_over;
    assign obs_win[0]   = if0.winner;
    assign obs_score[1] = if1.score_bcd;  assign obs_best[1] = if1.best_bcd;
    assign obs_event[1] = if1.score_event; assign obs_over[1] = if1.game_over;
    assign obs_win[1]   = if1.winner;
    assign obs_score[2] = if2.score_bcd;  assign obs_best[2] = if2.best_bcd;
    assign obs_event[2] = if2.score_event; assign obs_over[2] = if2.game_over;
    assign obs_win[2]   = if2.winner;

    // Reference model: scores as plain integers 0..99.
    localparam int MAXV = 99;
    int         wrap_cfg [3] = '{1, 0, 1};
    int         win_cfg  [3] = '{0, 0, 11};
    int         m_score  [3][2];
    int         m_best   [3][2];
    int         m_old    [2];
    int         m_winner [3];
    bit         m_over   [3];
    bit         m_event  [3];
    bit         m_found;
    int         nv;
    logic [1:0] m_ph, m_pm, m_hr, m_mr;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int d = 0; d < 3; d++) begin
                for (int p = 0; p < 2; p++) begin
                    m_score[d][p] = 0;
                    m_best[d][p]  = 0;
                end
                m_winner[d] = 0;
                m_over[d]   = 1'b0;
                m_event[d]  = 1'b0;
            end
            m_ph = 2'b00;
            m_pm = 2'b00;
        end else begin
            m_hr = hit & ~m_ph;
            m_mr = miss & ~m_pm;
            for (int d = 0; d < 3; d++) begin
                m_found = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    m_old[p] = m_score[d][p];
                    if (m_old[p] > m_best[d][p]) m_best[d][p] = m_old[p];
                end
                if (clear) begin
                    for (int p = 0; p < 2; p++) begin
                        m_score[d][p] = 0;
                        m_best[d][p]  = 0;
                    end
                    m_over[d]   = 1'b0;
                    m_winner[d] = 0;
                end else if (!m_over[d]) begin
                    for (int p = 0; p < 2; p++) begin
                        if (m_mr[p]) begin
                            m_score[d][p] = 0;
                        end else if (m_hr[p]) begin
                            if (m_score[d][p] == MAXV) nv = (wrap_cfg[d] != 0) ? 0 : MAXV;
                            else                       nv = m_score[d][p] + 1;
                            if (nv != m_score[d][p] && win_cfg[d] != 0 && nv == win_cfg[d] && !m_found) begin
                                m_found     = 1'b1;
                                m_winner[d] = p;
                                m_over[d]   = 1'b1;
                            end
                            m_score[d][p] = nv;
                        end
                    end
                end
                m_event[d] = (m_score[d][0] != m_old[0]) || (m_score[d][1] != m_old[1]);
            end
            m_ph = hit;
            m_pm = miss;
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] tens, ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d score", d), 32'(obs_score[d]),
                  32'({to_bcd(m_score[d][1]), to_bcd(m_score[d][0])}));
            check($sformatf("d%0d best", d), 32'(obs_best[d]),
                  32'({to_bcd(m_best[d][1]), to_bcd(m_best[d][0])}));
            check($sformatf("d%0d event", d), 32'(obs_event[d]), 32'(m_event[d]));
            check($sformatf("d%0d game_over", d), 32'(obs_over[d]), 32'(m_over[d]));
            check($sformatf("d%0d winner", d), 32'(obs_win[d]), 32'(m_over[d] ? m_winner[d] : 0));
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
        check_all();
    endtask

    task automatic pulse(input logic [1:0] h, input logic [1:0] m);
        hit  = h;
        miss = m;
        tick();
        hit  = 2'b00;
        miss = 2'b00;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge Clock);
        check_all();
        Reset = 1'b1;
        tick();

        // Twelve single-cycle hits on player 0
        ev_cnt = 0;
        repeat (12) begin
            hit[0] = 1'b1;
            tick();
            ev_cnt += int'(obs_event[0]);
            hit[0] = 1'b0;
            tick();
            ev_cnt += int'(obs_event[0]);
        end
        check("d0 twelve hits", 32'(obs_score[0]), 32'h0012);
        check("d0 event count", 32'(ev_cnt), 32'd12);

        // Held level counts once
        hit[1] = 1'b1;
        repeat (50) tick();
        hit[1] = 1'b0;
        tick();
        check("d0 held hit p1", 32'(obs_score[0][15:8]), 32'h01);

        // Wrap versus saturate at max
        do_clear();
        repeat (99) pulse(2'b01, 2'b00);
        check("d0 at 99", 32'(obs_score[0][7:0]), 32'h99);
        check("d1 at 99", 32'(obs_score[1][7:0]), 32'h99);
        hit[0] = 1'b1;
        tick();
        check("d0 wrapped", 32'(obs_score[0][7:0]), 32'h00);
        check("d1 saturated", 32'(obs_score[1][7:0]), 32'h99);
        check("d1 no event at max", 32'(obs_event[1]), 32'd0);
        hit[0] = 1'b0;
        tick();
        check("d0 best 99", 32'(obs_best[0][7:0]), 32'h99);

        // Simultaneous hit and miss on player 0, hit on player 1
        do_clear();
        repeat (7) pulse(2'b01, 2'b00);
        tick();
        tick();
        hit  = 2'b11;
        miss = 2'b01;
        tick();
        check("d0 miss wins", 32'(obs_score[0][7:0]), 32'h00);
        check("d0 p1 increments", 32'(obs_score[0][15:8]), 32'h01);
        hit  = 2'b00;
        miss = 2'b00;
        tick();
        check("d0 best stays 7", 32'(obs_best[0][7:0]), 32'h07);

        // Win at 11 with both players reaching it together
        do_clear();
        repeat (10) pulse(2'b11, 2'b00);
        check("d2 both at 10", 32'(obs_score[2]), 32'h1010);
        hit = 2'b11;
        tick();
        check("d2 game_over", 32'(obs_over[2]), 32'd1);
        check("d2 winner", 32'(obs_win[2]), 32'd0);
        check("d2 both at 11", 32'(obs_score[2]), 32'h1111);
        hit = 2'b00;
        tick();
        repeat (3) pulse(2'b11, 2'b00);
        repeat (2) pulse(2'b00, 2'b11);
        check("d2 frozen", 32'(obs_score[2]), 32'h1111);
        do_clear();
        check("d2 cleared score", 32'(obs_score[2]), 32'h0000);
        check("d2 cleared over", 32'(obs_over[2]), 32'd0);

        // Asynchronous reset mid-count while a hit rises
        repeat (39) pulse(2'b01, 2'b00);
        check("d0 at 39", 32'(obs_score[0][7:0]), 32'h39);
        hit[0] = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        check_all();
        check("d0 async reset", 32'(obs_score[0]), 32'h0000);
        @(negedge Clock);
        Reset = 1'b1;
        tick();
        check("d0 one count after reset", 32'(obs_score[0][7:0]), 32'h01);
        repeat (3) tick();
        check("d0 still one", 32'(obs_score[0][7:0]), 32'h01);
        hit = 2'b00;
        tick();

        // Randomized traffic
        repeat (600) begin
            hit   = 2'($urandom);
            miss  = ($urandom_range(0, 39) == 0) ? 2'($urandom) : 2'b00;
            clear = ($urandom_range(0, 99) == 0);
            tick();
        end
        hit   = 2'b00;
        miss  = 2'b00;
        clear = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
